// File: rtl/wb_write_queue_pkg.sv
// Shared constants and the queue entry record for the register-file write queue.
// The optional flush port is enabled by defining WBQ_FLUSH_EN.
package wb_write_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int WBQ_DEPTH  = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic [WORD_W-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/wb_write_queue_fwd_match.sv
// Forwarding lookup: finds the youngest valid queue entry whose destination
// matches one decode source index and returns its data.
module wb_fwd_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_dest,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
  input  logic [PTR_W-1:0]             i_head,
  input  logic [ADDR_W-1:0]            i_src,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_val
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest starting at head so a later match overrides an earlier one.
  always_comb begin
    o_hit = 1'b0;
    o_val = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if ((i_src != '0) && i_valid[w_idx] && (i_dest[w_idx] == i_src)) begin
        o_hit = 1'b1;
        o_val = i_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Buffers register write results from long-latency producers and drains one per
// granted cycle to the register file, with two forwarding ports. Optional: WBQ_FLUSH_EN.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = WORD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef WBQ_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_grant,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_dest,
  output logic [DATA_W-1:0] wr_val,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_val,
  output logic [DATA_W-1:0] fwd2_val,
  output logic [CNT_W-1:0]  count
);

  // Handshakes: a producer write transfers on a posedge where in_valid && in_ready;
  // a register-file write retires on a posedge where wr_en && wr_grant.

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_dest;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;

  logic w_flush;
  logic w_full;
  logic w_push;
  logic w_pop;

`ifdef WBQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Full blocks pushes even when a pop happens in the same cycle.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = !w_full && !w_flush;
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push   = in_valid && in_ready && (in_dest != '0);
  assign wr_en    = (r_count != '0) && !w_flush;
  assign w_pop    = wr_en && wr_grant;
  assign wr_dest  = wr_en ? r_dest[r_head] : '0;
  assign wr_val   = wr_en ? r_data[r_head] : '0;
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dest  <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_dest[r_tail]  <= in_dest;
        r_data[r_tail]  <= in_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .i_valid (r_valid),
    .i_dest  (r_dest),
    .i_data  (r_data),
    .i_head  (r_head),
    .i_src   (src1),
    .o_hit   (fwd1_hit),
    .o_val   (fwd1_val)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .i_valid (r_valid),
    .i_dest  (r_dest),
    .i_data  (r_data),
    .i_head  (r_head),
    .i_src   (src2),
    .o_hit   (fwd2_hit),
    .o_val   (fwd2_val)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized scoreboard bench for wb_write_queue; the reference model is a plain
// queue of pending {dest, data} writes updated once per cycle.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int DEPTH  = WBQ_DEPTH;
  localparam int ADDR_W = REG_ADDR_W;
  localparam int DATA_W = WORD_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int ENT_W  = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              wr_grant;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dest;
  logic [DATA_W-1:0] wr_val;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_val;
  logic [DATA_W-1:0] fwd2_val;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ENT_W-1:0] exp_q[$];

  wb_write_queue dut (
    .clk      (clk),
    .rst      (rst),
`ifdef WBQ_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .wr_grant (wr_grant),
    .wr_en    (wr_en),
    .wr_dest  (wr_dest),
    .wr_val   (wr_val),
    .src1     (src1),
    .src2     (src2),
    .fwd1_hit (fwd1_hit),
    .fwd2_hit (fwd2_hit),
    .fwd1_val (fwd1_val),
    .fwd2_val (fwd2_val),
    .count    (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Youngest pending write to s, as {hit, data}.
  function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] s);
    logic [ENT_W-1:0] e;
    if (s == '0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      e = exp_q[i];
      if (e[DATA_W +: ADDR_W] == s) return {1'b1, e[DATA_W-1:0]};
    end
    return '0;
  endfunction

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  // Monitor / scoreboard: compare on the falling edge, then advance the model
  // with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    logic [DATA_W:0]  f1;
    logic [DATA_W:0]  f2;
    logic [ENT_W-1:0] head;
    logic             room;
    if (!rst) begin
      exp_q.delete();
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_count", count, 0);
      check("rst_wr_dest", wr_dest, 0);
      check("rst_wr_val", wr_val, 0);
      check("rst_fwd1_hit", fwd1_hit, 0);
      check("rst_fwd2_hit", fwd2_hit, 0);
      check("rst_fwd1_val", fwd1_val, 0);
      check("rst_fwd2_val", fwd2_val, 0);
    end else begin
      room = (exp_q.size() < DEPTH);
      f1 = model_fwd(src1);
      f2 = model_fwd(src2);
      check("count", count, exp_q.size());
      check("in_ready", in_ready, room && !flush);
      check("wr_en", wr_en, (exp_q.size() > 0) && !flush);
      check("fwd1_hit", fwd1_hit, f1[DATA_W]);
      check("fwd1_val", fwd1_val, f1[DATA_W-1:0]);
      check("fwd2_hit", fwd2_hit, f2[DATA_W]);
      check("fwd2_val", fwd2_val, f2[DATA_W-1:0]);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) begin
          head = exp_q[0];
          check("wr_dest", wr_dest, head[DATA_W +: ADDR_W]);
          check("wr_val", wr_val, head[DATA_W-1:0]);
          if (wr_grant) void'(exp_q.pop_front());
        end
        if (in_valid && room && (in_dest != '0)) exp_q.push_back({in_dest, in_data});
      end
    end
  end

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_dest  = 5'd3;
    in_data  = 32'hDEADBEEF;
    wr_grant = 1'b0;
    src1     = 5'd3;
    src2     = 5'd0;
    repeat (3) step();

    // First push after reset appears on wr_* one cycle later.
    rst      = 1'b1;
    push(5'd3, 32'hA5A5A5A5);
    step();
    wr_grant = 1'b1;
    repeat (2) step();
    wr_grant = 1'b0;

    // Fill to DEPTH, refused fifth push, single-cycle grant.
    for (int d = 1; d <= 4; d++) push(ADDR_W'(d), $urandom);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    push(5'd7, 32'h77777777);
    wr_grant = 1'b1;
    step();
    wr_grant = 1'b0;
    check("after_pop_count", count, 3);
    check("after_pop_in_ready", in_ready, 1);
    step();
    wr_grant = 1'b1;
    repeat (4) step();

    // Forwarding priority and register-0 writes.
    wr_grant = 1'b0;
    src1 = 5'd5;
    src2 = 5'd0;
    push(5'd5, 32'h11);
    push(5'd5, 32'h22);
    check("fwd_youngest_hit", fwd1_hit, 1);
    check("fwd_youngest_val", fwd1_val, 32'h22);
    push(5'd0, 32'h33);
    check("dest0_count", count, 2);
    check("src0_no_hit", fwd2_hit, 0);

    // Simultaneous push and pop at count=2.
    wr_grant = 1'b1;
    push(5'd9, 32'h99);
    check("simul_count", count, 2);
    wr_grant = 1'b0;

    // Randomized traffic: first heavily backed up, then mostly draining.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_dest  = ADDR_W'($urandom_range(0, 7));
      in_data  = $urandom;
      wr_grant = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      src1     = ADDR_W'($urandom_range(0, 7));
      src2     = ADDR_W'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0;
    wr_grant = 1'b1;
    repeat (6) step();
    wr_grant = 1'b0;

    // Asynchronous reset with entries pending.
    push(5'd1, 32'h1);
    push(5'd2, 32'h2);
    push(5'd4, 32'h4);
    #1;
    check("pre_reset_count", count, 3);
    #1;
    rst = 1'b0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_count", count, 0);
    repeat (2) step();
    rst = 1'b1;
    step();

`ifdef WBQ_FLUSH_EN
    push(5'd6, 32'h6);
    push(5'd7, 32'h7);
    push(5'd8, 32'h8);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_dest  = 5'd10;
    in_data  = 32'hF1F1F1F1;
    #2;
    check("flush_wr_en", wr_en, 0);
    check("flush_in_ready", in_ready, 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 0);
    src1 = 5'd10;
    #1;
    check("flush_push_absent", fwd1_hit, 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
